axi_burst_writer: RTL and testbench

//  AXI4 write-master controller between the 256-bit word async FIFO (read side, axi_clk domain) and DDR.

---
 rtl/axi_burst_writer_if.sv | 39 +++
 rtl/axi_burst_writer.sv | 189 ++++++++++++++++++
 tb/tb_axi_burst_writer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_writer_if.sv
// Bundle of the FIFO read port and AXI4 write channels seen by axi_burst_writer.
// The master modport is the controller side; the slave modport is the FIFO/DDR side.
interface axi_burst_writer_if #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   fifo_data;
    logic                    fifo_empty;
    logic                    fifo_ren;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        input  fifo_data, fifo_empty, awready, wready, bresp, bvalid,
        output fifo_ren, awaddr, awlen, awsize, awburst, awvalid,
               wdata, wstrb, wlast, wvalid, bready
    );

    modport slave (
        output fifo_data, fifo_empty, awready, wready, bresp, bvalid,
        input  fifo_ren, awaddr, awlen, awsize, awburst, awvalid,
               wdata, wstrb, wlast, wvalid, bready
    );
endinterface

// File: rtl/axi_burst_writer.sv
// AXI4 write master: drains FIFO words into fixed-length INCR bursts over a
// circular DDR region, tracking completed bursts and a sticky response error.
module axi_burst_writer #(
    parameter int unsigned           DATA_WIDTH = 256,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           BURST_LEN  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           BUF_WORDS  = 1024
) (
    input  logic                 axi_clk,
    input  logic                 rst_n,
    input  logic                 start,
    axi_burst_writer_if.master   m_axi,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          burst_cnt
);

    localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int unsigned CNT_W          = $clog2(BURST_LEN + 1);
    localparam logic [63:0] BURST_BYTES64  = 64'(BURST_LEN) * 64'(BYTES_PER_BEAT);
    localparam logic [63:0] REGION_BYTES64 = 64'(BUF_WORDS) * 64'(BYTES_PER_BEAT);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_BYTES64);
    localparam logic [ADDR_WIDTH-1:0] REGION_END  = ADDR_WIDTH'(64'(BASE_ADDR) + REGION_BYTES64);
    localparam logic [CNT_W-1:0]      LEN_CNT     = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BURST_LEN - 1);

    // Elaboration-time guards on the parameter set.
    if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_dw
        $error("axi_burst_writer: DATA_WIDTH must be a power of 2 >= 8");
    end
    if ((BURST_LEN < 1) || (BURST_LEN > 16) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_bad_len
        $error("axi_burst_writer: BURST_LEN must be a power of 2 in 1..16");
    end
    if (BURST_BYTES64 > 64'd4096) begin : g_bad_4k
        $error("axi_burst_writer: burst exceeds 4 KB");
    end
    if (((BUF_WORDS % BURST_LEN) != 0) || ((BUF_WORDS & (BUF_WORDS - 1)) != 0)) begin : g_bad_buf
        $error("axi_burst_writer: BUF_WORDS must be a power of 2 multiple of BURST_LEN");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  r_state,    w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cur_addr, w_cur_addr_nxt;
    logic [ADDR_WIDTH-1:0]   r_awaddr,   w_awaddr_nxt;
    logic                    r_awvalid,  w_awvalid_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata,    w_wdata_nxt;
    logic                    r_wvalid,   w_wvalid_nxt;
    logic                    r_wlast,    w_wlast_nxt;
    logic                    r_bready,   w_bready_nxt;
    logic                    r_busy,     w_busy_nxt;
    logic                    r_err,      w_err_nxt;
    logic [15:0]             r_burst_cnt, w_burst_cnt_nxt;
    logic [CNT_W-1:0]        r_beat_cnt, w_beat_cnt_nxt;
    logic [CNT_W-1:0]        r_fetch_cnt, w_fetch_cnt_nxt;
    logic                    r_rd_pend,  w_rd_pend_nxt;
    logic                    w_fifo_ren;
    logic [ADDR_WIDTH-1:0]   w_addr_inc;

    assign w_addr_inc = r_cur_addr + BURST_BYTES;

    // Next-state and datapath decode; every target starts from its held value.
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_addr_nxt  = r_cur_addr;
        w_awaddr_nxt    = r_awaddr;
        w_awvalid_nxt   = r_awvalid;
        w_wdata_nxt     = r_wdata;
        w_wvalid_nxt    = r_wvalid;
        w_wlast_nxt     = r_wlast;
        w_bready_nxt    = r_bready;
        w_err_nxt       = r_err;
        w_burst_cnt_nxt = r_burst_cnt;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_fetch_cnt_nxt = r_fetch_cnt;
        w_fifo_ren      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start && !m_axi.fifo_empty) begin
                    w_state_nxt   = ADDR;
                    w_awaddr_nxt  = r_cur_addr;
                    w_awvalid_nxt = 1'b1;
                end
            end
            ADDR: begin
                if (r_awvalid && m_axi.awready) begin
                    w_awvalid_nxt = 1'b0;
                    w_state_nxt   = DATA;
                end
            end
            DATA: begin
                // One outstanding FIFO read at a time; only fetch once the W slot is free.
                w_fifo_ren = !m_axi.fifo_empty && !r_rd_pend &&
                             (r_fetch_cnt < LEN_CNT) && (!r_wvalid || m_axi.wready);
                if (w_fifo_ren) begin
                    w_fetch_cnt_nxt = r_fetch_cnt + CNT_W'(1);
                end
                if (r_rd_pend) begin
                    w_wdata_nxt  = m_axi.fifo_data;
                    w_wvalid_nxt = 1'b1;
                    w_wlast_nxt  = (r_beat_cnt == LAST_BEAT);
                end else if (r_wvalid && m_axi.wready) begin
                    w_wvalid_nxt   = 1'b0;
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    if (r_wlast) begin
                        w_wlast_nxt     = 1'b0;
                        w_beat_cnt_nxt  = '0;
                        w_fetch_cnt_nxt = '0;
                        w_bready_nxt    = 1'b1;
                        w_state_nxt     = RESP;
                    end
                end
            end
            RESP: begin
                if (r_bready && m_axi.bvalid) begin
                    w_bready_nxt    = 1'b0;
                    w_err_nxt       = r_err | (m_axi.bresp != 2'b00);
                    w_burst_cnt_nxt = r_burst_cnt + 16'd1;
                    w_cur_addr_nxt  = (w_addr_inc == REGION_END) ? BASE_ADDR : w_addr_inc;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_rd_pend_nxt = w_fifo_ren;
        w_busy_nxt    = (w_state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cur_addr  <= BASE_ADDR;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
            r_fetch_cnt <= '0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_wlast     <= w_wlast_nxt;
            r_bready    <= w_bready_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
            r_rd_pend   <= w_rd_pend_nxt;
        end
    end

    assign m_axi.fifo_ren = w_fifo_ren;
    assign m_axi.awaddr   = r_awaddr;
    assign m_axi.awlen    = 8'(BURST_LEN - 1);
    assign m_axi.awsize   = 3'($clog2(BYTES_PER_BEAT));
    assign m_axi.awburst  = 2'b01;
    assign m_axi.awvalid  = r_awvalid;
    assign m_axi.wdata    = r_wdata;
    assign m_axi.wstrb    = '1;
    assign m_axi.wlast    = r_wlast;
    assign m_axi.wvalid   = r_wvalid;
    assign m_axi.bready   = r_bready;
    assign busy           = r_busy;
    assign err            = r_err;
    assign burst_cnt      = r_burst_cnt;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer: FIFO and AXI slave models driven per cycle,
// with a data scoreboard and address model checked at each handshake.
module tb_axi_burst_writer;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        err;
    logic [15:0] burst_cnt;

    axi_burst_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_burst_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(4),
        .BASE_ADDR(32'h0), .BUF_WORDS(8)
    ) dut (
        .axi_clk(clk), .rst_n(rst_n), .start(start), .m_axi(bus.master),
        .busy(busy), .err(err), .burst_cnt(burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] m_addr = '0;
    int            b_cnt = 0;
    int            aw_cnt = 0;
    int            ren_cnt = 0;
    int            beat_idx = 0;
    int            aw_stall = 0;
    bit            w_toggle = 1'b0;
    logic [1:0]    bresp_val = 2'b00;
    logic          ren_seen = 1'b0;
    logic          prev_aw_wait = 1'b0;
    logic          prev_w_wait = 1'b0;
    logic [AW-1:0] prev_awaddr = '0;
    logic [DW-1:0] prev_wdata = '0;
    logic          prev_wlast = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int k);
        return {8{32'hC0DE_0000 + 32'(k)}};
    endfunction

    task automatic push_word(input int k);
        fifo_q.push_back(mk_word(k));
        exp_data.push_back(mk_word(k));
    endtask

    // One clock: update FIFO/slave inputs just after the edge, then observe handshakes.
    task automatic cycle();
        logic [DW-1:0] exp_w;
        @(posedge clk);
        #1;
        if (ren_seen) begin
            if (fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
            else bus.fifo_data = 'x;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.awready = (aw_stall == 0);
        if (bus.awvalid && aw_stall > 0) aw_stall--;
        bus.wready = w_toggle ? ~bus.wready : 1'b1;
        bus.bvalid = bus.bready;
        bus.bresp  = bresp_val;
        #1;
        ren_seen = bus.fifo_ren;
        if (bus.fifo_ren) begin
            check("ren_while_empty", DW'(bus.fifo_empty), DW'(0));
            ren_cnt++;
        end
        if (prev_aw_wait) begin
            check("awvalid_held", DW'(bus.awvalid), DW'(1));
            check("awaddr_held", DW'(bus.awaddr), DW'(prev_awaddr));
        end
        if (bus.awvalid && bus.awready) begin
            check("awaddr", DW'(bus.awaddr), DW'(m_addr));
            aw_cnt++;
        end
        prev_aw_wait = bus.awvalid && !bus.awready;
        prev_awaddr  = bus.awaddr;
        if (prev_w_wait) begin
            check("wvalid_held", DW'(bus.wvalid), DW'(1));
            check("wdata_held", bus.wdata, prev_wdata);
            check("wlast_held", DW'(bus.wlast), DW'(prev_wlast));
        end
        if (bus.wvalid && bus.wready) begin
            exp_w = (exp_data.size() > 0) ? exp_data.pop_front() : 'x;
            check("wdata", bus.wdata, exp_w);
            check("wlast", DW'(bus.wlast), DW'(beat_idx == 3));
            beat_idx = (beat_idx + 1) % 4;
        end
        prev_w_wait = bus.wvalid && !bus.wready;
        prev_wdata  = bus.wdata;
        prev_wlast  = bus.wlast;
        if (bus.bvalid && bus.bready) begin
            check("ren_per_burst", DW'(ren_cnt), DW'(4));
            ren_cnt = 0;
            m_addr = (m_addr + 32'h80) % 32'h100;
            b_cnt++;
        end
    endtask

    task automatic wait_bursts(input int target, input int budget, input string tag);
        int n = 0;
        while (b_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_done"}, DW'(b_cnt), DW'(target));
        cycle();
        check({tag, "_burst_cnt"}, DW'(burst_cnt), DW'(target));
        check({tag, "_busy"}, DW'(busy), DW'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        bus.fifo_data  = '0;
        bus.fifo_empty = 1'b1;
        bus.awready    = 1'b1;
        bus.wready     = 1'b1;
        bus.bresp      = 2'b00;
        bus.bvalid     = 1'b0;

        // Reset with start high and empty FIFO
        repeat (3) cycle();
        check("rst_awvalid", DW'(bus.awvalid), DW'(0));
        check("rst_awaddr", DW'(bus.awaddr), DW'(0));
        check("rst_wvalid", DW'(bus.wvalid), DW'(0));
        check("rst_wdata", bus.wdata, DW'(0));
        check("rst_bready", DW'(bus.bready), DW'(0));
        check("rst_ren", DW'(bus.fifo_ren), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_err", DW'(err), DW'(0));
        check("rst_burst_cnt", DW'(burst_cnt), DW'(0));
        check("awlen", DW'(bus.awlen), DW'(3));
        check("awsize", DW'(bus.awsize), DW'(5));
        check("awburst", DW'(bus.awburst), DW'(1));
        check("wstrb", DW'(bus.wstrb), DW'(32'hFFFF_FFFF));
        rst_n = 1'b1;
        repeat (5) cycle();
        check("idle_busy", DW'(busy), DW'(0));
        check("idle_no_aw", DW'(aw_cnt), DW'(0));

        // Two back-to-back bursts, always ready
        for (int k = 1; k <= 8; k++) push_word(k);
        wait_bursts(2, 200, "t2");
        check("t2_err", DW'(err), DW'(0));
        check("t2_aw_cnt", DW'(aw_cnt), DW'(2));

        // AW stalled five cycles, wready toggling
        aw_stall = 5;
        w_toggle = 1'b1;
        for (int k = 9; k <= 12; k++) push_word(k);
        wait_bursts(3, 300, "t3");
        w_toggle = 1'b0;

        // FIFO underrun mid-burst
        for (int k = 13; k <= 14; k++) push_word(k);
        repeat (20) cycle();
        check("t4_gap_wvalid", DW'(bus.wvalid), DW'(0));
        check("t4_gap_beats", DW'(beat_idx), DW'(2));
        check("t4_gap_busy", DW'(busy), DW'(1));
        for (int k = 15; k <= 16; k++) push_word(k);
        wait_bursts(4, 200, "t4");

        // Error response is sticky and does not stop the next burst
        bresp_val = 2'b10;
        for (int k = 17; k <= 20; k++) push_word(k);
        wait_bursts(5, 200, "t5a");
        check("t5_err_set", DW'(err), DW'(1));
        bresp_val = 2'b00;
        for (int k = 21; k <= 24; k++) push_word(k);
        wait_bursts(6, 200, "t5b");
        check("t5_err_sticky", DW'(err), DW'(1));

        // Reset during the second data beat
        for (int k = 25; k <= 28; k++) push_word(k);
        begin
            int n = 0;
            while (!(bus.wvalid && beat_idx == 1) && n < 100) begin
                cycle();
                n++;
            end
            check("t6_reached_beat2", DW'(bus.wvalid && beat_idx == 1), DW'(1));
        end
        rst_n = 1'b0;
        #1;
        check("t6_wvalid", DW'(bus.wvalid), DW'(0));
        check("t6_awvalid", DW'(bus.awvalid), DW'(0));
        check("t6_busy", DW'(busy), DW'(0));
        check("t6_err", DW'(err), DW'(0));
        check("t6_burst_cnt", DW'(burst_cnt), DW'(0));
        check("t6_ren", DW'(bus.fifo_ren), DW'(0));
        fifo_q.delete();
        exp_data.delete();
        m_addr = '0;
        b_cnt = 0;
        ren_cnt = 0;
        beat_idx = 0;
        ren_seen = 1'b0;
        prev_aw_wait = 1'b0;
        prev_w_wait = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int k = 29; k <= 32; k++) push_word(k);
        wait_bursts(1, 200, "t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
